cpu_sequencer: RTL and testbench
================================

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter RESET_PC, default 4'h0: PC value loaded on reset.
REQ-002 The block SHALL have port clk_cpu  input  1  CPU clock; all state updates on the rising edge.
REQ-003 The block SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port run  input  1  level; 1 = free-run instructions.
REQ-005 The block SHALL have port step_req  input  1  request to execute exactly one instruction.
REQ-006 The block SHALL have port inst  input  8  ROM word at address pc; [7:4] opcode, [3:0] immediate.
REQ-007 The block SHALL have port alu_carry  input  1  ALU carry-out for the current ir.
REQ-008 The block SHALL have port pc  output  4  program counter, registered.
REQ-009 The block SHALL have port ir  output  8  instruction register, registered.
REQ-010 The block SHALL have ports reg_a_load, reg_b_load and out_load  output  1 each  datapath load strobes.
REQ-011 The block SHALL have port carry_flag  output  1  registered carry flag.
REQ-012 The block SHALL have ports halted and step_ack  output  1 each  status outputs.
REQ-013 The block SHALL have port state  output  2  FSM state: IDLE=0, FETCH=1, EXEC=2, HALT=3.

Function
REQ-014 FSM transitions SHALL be: IDLE->FETCH when run=1 or step_req=1; FETCH->EXEC unconditionally; EXEC->HALT/IDLE/FETCH per REQ-019; HALT->HALT until reset.
REQ-015 In FETCH, ir SHALL load inst; pc SHALL NOT change.
REQ-016 Strobes SHALL be combinational and asserted only while state=EXEC.
- reg_a_load for ir[7:4] in {0000 ADD A,Im; 0001 MOV A,B; 0011 MOV A,Im}.
- reg_b_load for {0100 MOV B,A; 0101 ADD B,Im; 0111 MOV B,Im}.
- out_load for 1011 OUT Im.
- At most one strobe SHALL be high; all other opcodes SHALL assert none.
REQ-017 Carry flag update on leaving EXEC:
- carry_flag <= alu_carry for ADD opcodes 0000/0101.
- carry_flag <= 0 for every other opcode.
REQ-018 PC update on leaving EXEC:
- 1111 JMP: pc <= ir[3:0].
- 1110 JNC: pc <= ir[3:0] if carry_flag=0, using the flag value before this update; otherwise pc+1.
- All other opcodes: pc <= pc+1, with 4'hF wrapping to 4'h0.
REQ-019 Exit from EXEC:
- JMP with ir[3:0]==pc -> HALT.
- Else, instruction entered via step -> IDLE.
- Else, run=1 -> FETCH.
- Else -> IDLE.
REQ-020 Each instruction SHALL take exactly 2 cycles (FETCH+EXEC); continuous run gives 1 instruction per 2 cycles.
REQ-021 In IDLE with run=1 and step_req=1 simultaneously, run SHALL win and the step SHALL be ignored; step_req outside IDLE SHALL be ignored, not queued.
REQ-022 step_ack SHALL pulse high for one cycle on the EXEC->IDLE transition of a stepped instruction.
REQ-023 halted SHALL be 1 exactly when state=HALT; in HALT all strobes SHALL be 0 and pc, ir, carry_flag SHALL hold.
REQ-024 Deasserting run during FETCH or EXEC SHALL complete the current instruction, then go to IDLE.

Reset
REQ-025 On reset_n=0, immediately and independent of clk_cpu, the block SHALL set: state=IDLE, pc=RESET_PC, ir=8'h00, carry_flag=0, step_ack=0, halted=0, and all strobes=0.
REQ-026 Reset asserted mid-instruction SHALL abort it with no load strobe and no pc change.

Configuration
REQ-027 With CPU_SEQ_SINGLE_STEP_EN defined, step_req/step_ack SHALL behave per REQ-014, REQ-019, REQ-021 and REQ-022.
REQ-028 Without CPU_SEQ_SINGLE_STEP_EN, step_req SHALL be ignored, step_ack SHALL be tied 0, and IDLE SHALL leave only on run=1.

Verification
REQ-029 Reset, run=1, ROM 0:8'h33 -> cycle 1 FETCH ir=33, cycle 2 reg_a_load=1, pc=1 after EXEC.
REQ-030 ADD A,Im 8'h0F with alu_carry=1, then JNC 8'hE5 -> carry_flag=1, pc=next+1 (no jump); repeat with alu_carry=0 -> pc=5.
REQ-031 pc=4'hF executing MOV A,Im under run -> pc wraps to 4'h0.
REQ-032 JMP 8'hF7 at pc=7 -> state=HALT, halted=1, strobes 0, pc stays 7 for 10+ cycles.
REQ-033 Macro defined, run=0, step_req pulse -> one FETCH+EXEC, step_ack 1-cycle pulse, return to IDLE; step_req together with run=1 -> no step_ack.
REQ-034 reset_n low during EXEC of 8'h35 -> reg_a_load drops immediately, pc=RESET_PC, state=IDLE.

Source files
------------

// File: rtl/cpu_sequencer.sv
// Fetch/execute sequencer for a 4-bit-address toy CPU: IDLE/FETCH/EXEC/HALT control, pc, ir and carry flag.
// Optional single-step support is enabled by defining CPU_SEQ_SINGLE_STEP_EN.
module cpu_sequencer #(
  parameter logic [3:0] RESET_PC = 4'h0
) (
  input  logic       clk_cpu,
  input  logic       reset_n,
  input  logic       run,
  input  logic       step_req,
  input  logic [7:0] inst,
  input  logic       alu_carry,
  output logic [3:0] pc,
  output logic [7:0] ir,
  output logic       reg_a_load,
  output logic       reg_b_load,
  output logic       out_load,
  output logic       carry_flag,
  output logic       halted,
  output logic       step_ack,
  output logic [1:0] state
);

  localparam int unsigned PcW   = 4;
  localparam int unsigned InstW = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_MOV_AI = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_MOV_BI = 4'b0111;
  localparam logic [3:0] OP_OUT    = 4'b1011;
  localparam logic [3:0] OP_JNC    = 4'b1110;
  localparam logic [3:0] OP_JMP    = 4'b1111;

  state_e           state_q, state_d;
  logic [PcW-1:0]   pc_q, pc_d;
  logic [InstW-1:0] ir_q, ir_d;
  logic             carry_q, carry_d;
  logic             step_ack_q, step_ack_d;
  logic             stepped_q, stepped_d;
  logic             step_go;

  logic [3:0]     opcode;
  logic [PcW-1:0] imm;

  assign opcode = ir_q[7:4];
  assign imm    = ir_q[3:0];

`ifdef CPU_SEQ_SINGLE_STEP_EN
  assign step_go  = step_req;
  assign step_ack = step_ack_q;
`else
  logic unused_step;
  assign step_go     = 1'b0;
  assign step_ack    = 1'b0;
  assign unused_step = step_req ^ step_ack_q;
`endif

  // Next-state, pc, ir and flag computation
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    carry_d    = carry_q;
    step_ack_d = 1'b0;
    stepped_d  = stepped_q;
    unique case (state_q)
      ST_IDLE: begin
        // run has priority; a simultaneous step is dropped
        if (run) begin
          state_d   = ST_FETCH;
          stepped_d = 1'b0;
        end else if (step_go) begin
          state_d   = ST_FETCH;
          stepped_d = 1'b1;
        end
      end
      ST_FETCH: begin
        ir_d    = inst;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        carry_d = ((opcode == OP_ADD_A) || (opcode == OP_ADD_B)) ? alu_carry : 1'b0;
        if (opcode == OP_JMP) begin
          pc_d = imm;
        end else if ((opcode == OP_JNC) && !carry_q) begin
          pc_d = imm;
        end else begin
          pc_d = pc_q + PcW'(1);
        end
        // A jump to its own address is the halt idiom
        if ((opcode == OP_JMP) && (imm == pc_q)) begin
          state_d = ST_HALT;
        end else if (stepped_q) begin
          state_d    = ST_IDLE;
          step_ack_d = 1'b1;
        end else if (run) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_cpu or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= 8'h00;
      carry_q    <= 1'b0;
      step_ack_q <= 1'b0;
      stepped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      carry_q    <= carry_d;
      step_ack_q <= step_ack_d;
      stepped_q  <= stepped_d;
    end
  end

  // Datapath load strobes, decoded from ir only while executing
  always_comb begin
    reg_a_load = 1'b0;
    reg_b_load = 1'b0;
    out_load   = 1'b0;
    if (state_q == ST_EXEC) begin
      unique case (opcode)
        OP_ADD_A, OP_MOV_AB, OP_MOV_AI: reg_a_load = 1'b1;
        OP_MOV_BA, OP_ADD_B, OP_MOV_BI: reg_b_load = 1'b1;
        OP_OUT:                         out_load   = 1'b1;
        default: ;
      endcase
    end
  end

  assign pc         = pc_q;
  assign ir         = ir_q;
  assign carry_flag = carry_q;
  assign halted     = (state_q == ST_HALT);
  assign state      = 2'(state_q);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: instruction-level reference model plus directed programs.
module tb_cpu_sequencer;

  logic       clk_cpu = 1'b0;
  logic       reset_n;
  logic       run;
  logic       step_req;
  logic [7:0] inst;
  logic       alu_carry;
  logic [3:0] pc;
  logic [7:0] ir;
  logic       reg_a_load, reg_b_load, out_load;
  logic       carry_flag, halted, step_ack;
  logic [1:0] state;

  logic [7:0] rom [16];

`ifdef CPU_SEQ_SINGLE_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  int n_pass = 0;
  int n_total = 0;

  cpu_sequencer #(.RESET_PC(4'h0)) dut (
    .clk_cpu    (clk_cpu),
    .reset_n    (reset_n),
    .run        (run),
    .step_req   (step_req),
    .inst       (inst),
    .alu_carry  (alu_carry),
    .pc         (pc),
    .ir         (ir),
    .reg_a_load (reg_a_load),
    .reg_b_load (reg_b_load),
    .out_load   (out_load),
    .carry_flag (carry_flag),
    .halted     (halted),
    .step_ack   (step_ack),
    .state      (state)
  );

  always #5 clk_cpu = ~clk_cpu;

  assign inst = rom[pc];

  // Reference model: 0=IDLE 1=FETCH 2=EXEC 3=HALT, pc as a plain integer mod 16
  int         m_state;
  int         m_pc;
  logic [7:0] m_ir;
  logic       m_cf;
  logic       m_ack;
  logic       m_stepped;

  function automatic int next_pc(input logic [7:0] instr, input int cur, input logic cf);
    int op;
    int im;
    op = int'(instr[7:4]);
    im = int'(instr[3:0]);
    if (op == 15) return im;
    if (op == 14 && cf == 1'b0) return im;
    return (cur + 1) % 16;
  endfunction

  // Expected strobes as {out, b, a}
  function automatic logic [2:0] strobes_for(input int st, input logic [7:0] instr);
    if (st != 2) return 3'b000;
    case (int'(instr[7:4]))
      0, 1, 3: return 3'b001;
      4, 5, 7: return 3'b010;
      11:      return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  always @(posedge clk_cpu or negedge reset_n) begin
    if (!reset_n) begin
      m_state   <= 0;
      m_pc      <= 0;
      m_ir      <= 8'h00;
      m_cf      <= 1'b0;
      m_ack     <= 1'b0;
      m_stepped <= 1'b0;
    end else begin
      m_ack <= 1'b0;
      if (m_state == 0) begin
        if (run) begin
          m_state   <= 1;
          m_stepped <= 1'b0;
        end else if (STEP_EN && step_req) begin
          m_state   <= 1;
          m_stepped <= 1'b1;
        end
      end else if (m_state == 1) begin
        m_ir    <= rom[m_pc];
        m_state <= 2;
      end else if (m_state == 2) begin
        m_cf <= (m_ir[7:4] == 4'h0 || m_ir[7:4] == 4'h5) ? alu_carry : 1'b0;
        m_pc <= next_pc(m_ir, m_pc, m_cf);
        if (m_ir[7:4] == 4'hF && int'(m_ir[3:0]) == m_pc) m_state <= 3;
        else if (m_stepped) begin
          m_state <= 0;
          m_ack   <= 1'b1;
        end else m_state <= run ? 1 : 0;
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic check_all();
    logic [2:0] s;
    s = strobes_for(m_state, m_ir);
    chk("state", 8'(state), 8'(m_state));
    chk("pc", 8'(pc), 8'(m_pc));
    chk("ir", ir, m_ir);
    chk("carry_flag", 8'(carry_flag), 8'(m_cf));
    chk("halted", 8'(halted), 8'(m_state == 3));
    chk("step_ack", 8'(step_ack), 8'(m_ack));
    chk("reg_a_load", 8'(reg_a_load), 8'(s[0]));
    chk("reg_b_load", 8'(reg_b_load), 8'(s[1]));
    chk("out_load", 8'(out_load), 8'(s[2]));
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_cpu);
      @(negedge clk_cpu);
      check_all();
    end
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    run      = 1'b0;
    step_req = 1'b0;
    repeat (2) @(negedge clk_cpu);
    check_all();
    reset_n = 1'b1;
  endtask

  task automatic fill_rom(input logic [7:0] v);
    for (int i = 0; i < 16; i++) rom[i] = v;
  endtask

  initial begin
    reset_n   = 1'b0;
    run       = 1'b0;
    step_req  = 1'b0;
    alu_carry = 1'b1;
    fill_rom(8'hC0);
    rom[0] = 8'h33; rom[1] = 8'h0F; rom[2] = 8'hE5; rom[3] = 8'hF3; rom[5] = 8'hF5;

    // Reset values, then ADD with carry followed by a non-taken JNC
    do_reset();
    chk("rst_pc", 8'(pc), 8'h00);
    chk("rst_ir", ir, 8'h00);
    chk("rst_state", 8'(state), 8'h00);
    chk("rst_strobes", 8'({out_load, reg_b_load, reg_a_load}), 8'h00);
    run = 1'b1;
    cyc(1); chk("first_fetch_state", 8'(state), 8'h01);
    cyc(1); chk("mov_a_strobe", 8'(reg_a_load), 8'h01); chk("mov_a_ir", ir, 8'h33);
    cyc(1); chk("pc_after_mov", 8'(pc), 8'h01);
    cyc(2); chk("carry_set", 8'(carry_flag), 8'h01);
    cyc(2); chk("jnc_not_taken", 8'(pc), 8'h03); chk("carry_cleared", 8'(carry_flag), 8'h00);
    cyc(2); chk("halt_state", 8'(state), 8'h03); chk("halted", 8'(halted), 8'h01);
    cyc(12); chk("halt_pc_hold", 8'(pc), 8'h03);
    chk("halt_strobes", 8'({out_load, reg_b_load, reg_a_load}), 8'h00);

    // Same program without carry: JNC taken to 5
    alu_carry = 1'b0;
    do_reset();
    run = 1'b1;
    cyc(7); chk("jnc_taken", 8'(pc), 8'h05);
    cyc(4); chk("halt_at_5", 8'(halted), 8'h01); chk("halt_pc5", 8'(pc), 8'h05);

    // pc wrap F->0, then drop run during FETCH
    fill_rom(8'hC0);
    rom[0] = 8'hFF; rom[15] = 8'h31;
    do_reset();
    run = 1'b1;
    cyc(3); chk("jmp_to_f", 8'(pc), 8'h0F);
    cyc(2); chk("pc_wrap", 8'(pc), 8'h00);
    run = 1'b0;
    cyc(1); chk("finish_exec", 8'(state), 8'h02);
    cyc(1); chk("idle_after_run_drop", 8'(state), 8'h00); chk("pc_after_drop", 8'(pc), 8'h0F);
    cyc(3);

    // Strobe decode across opcode classes
    fill_rom(8'hC0);
    rom[0] = 8'h40; rom[1] = 8'h5A; rom[2] = 8'h72; rom[3] = 8'hB9;
    rom[4] = 8'h20; rom[5] = 8'hC0; rom[6] = 8'h1E; rom[7] = 8'hF7;
    alu_carry = 1'b1;
    do_reset();
    run = 1'b1;
    cyc(8); chk("out_strobe", 8'(out_load), 8'h01); chk("out_no_a", 8'(reg_a_load), 8'h00);
    cyc(2); chk("op2_no_strobe", 8'({out_load, reg_b_load, reg_a_load}), 8'h00);
    cyc(7); chk("jmp_f7_halt", 8'(halted), 8'h01); chk("jmp_f7_pc", 8'(pc), 8'h07);
    cyc(10); chk("f7_pc_hold", 8'(pc), 8'h07);

    // Reset in the middle of EXEC aborts the instruction
    fill_rom(8'hC0);
    rom[1] = 8'h35;
    do_reset();
    run = 1'b1;
    cyc(4); chk("exec_35_strobe", 8'(reg_a_load), 8'h01); chk("exec_35_pc", 8'(pc), 8'h01);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_strobe", 8'(reg_a_load), 8'h00);
    chk("abort_pc", 8'(pc), 8'h00);
    chk("abort_state", 8'(state), 8'h00);
    run = 1'b0;
    @(negedge clk_cpu);
    check_all();
    reset_n = 1'b1;
    cyc(2);

    fill_rom(8'hC0);
    rom[0] = 8'hB3;
`ifdef CPU_SEQ_SINGLE_STEP_EN
    // Single step: one FETCH+EXEC, one-cycle ack, back to IDLE
    do_reset();
    step_req = 1'b1;
    cyc(1); chk("step_fetch", 8'(state), 8'h01);
    step_req = 1'b0;
    cyc(1); chk("step_exec_out", 8'(out_load), 8'h01);
    cyc(1); chk("step_idle", 8'(state), 8'h00); chk("step_ack_hi", 8'(step_ack), 8'h01);
    chk("step_pc", 8'(pc), 8'h01);
    cyc(1); chk("step_ack_lo", 8'(step_ack), 8'h00); chk("step_stay_idle", 8'(state), 8'h00);
    // step together with run: run wins, no ack
    step_req = 1'b1;
    run = 1'b1;
    cyc(1); chk("run_step_fetch", 8'(state), 8'h01);
    step_req = 1'b0;
    cyc(2); chk("run_step_continue", 8'(state), 8'h01); chk("run_step_no_ack", 8'(step_ack), 8'h00);
    run = 1'b0;
    cyc(3); chk("run_step_idle", 8'(state), 8'h00);
`else
    // Without the step feature, step_req must not start an instruction
    do_reset();
    step_req = 1'b1;
    cyc(3); chk("no_step_idle", 8'(state), 8'h00); chk("no_step_ack", 8'(step_ack), 8'h00);
    chk("no_step_pc", 8'(pc), 8'h00);
    step_req = 1'b0;
    cyc(1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
